// File: rtl/trig_frame_builder.sv
// Trigger frame builder: timestamps trigger edges into a record FIFO and streams
// each record as a two-beat AXI-Stream frame to the inbound DMA port.
module trig_frame_builder #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BUSY_THRESH = 12,
    parameter logic [7:0]  FRAME_DEST  = 8'h00
) (
    input  logic        dmaClk,
    input  logic        dmaRstL,
    input  logic        enable,
    input  logic        trigger,
    input  logic        spill,
    output logic        dmaIbMaster_tValid,
    output logic [63:0] dmaIbMaster_tData,
    output logic [7:0]  dmaIbMaster_tKeep,
    output logic        dmaIbMaster_tLast,
    output logic [7:0]  dmaIbMaster_tDest,
    input  logic        dmaIbSlave_tReady,
    output logic        busy,
    output logic [31:0] trigCount,
    output logic [15:0] dropCount
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

    state_e        state_q, state_d;
    logic          trig_q, spill_q;
    logic [47:0]   ts_q;
    logic [15:0]   spill_num_q;
    logic [31:0]   trig_cnt_q;
    logic [15:0]   drop_cnt_q;
    logic          busy_q, busy_d;
    logic [CW-1:0] wr_ptr_q, rd_ptr_q;
    logic [95:0]   mem [FIFO_DEPTH];
    logic [95:0]   rec_q;

    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] occupancy;
    logic          fifo_empty, full, in_flight, frame_done;
    logic          trig_ev, spill_ev, push, pop, drop;

    // Occupancy includes the record sitting in the output register until its
    // frame completes, so the capacity seen by triggers is FIFO_DEPTH records.
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign in_flight  = (state_q != IDLE);
    assign occupancy  = fifo_cnt + CW'(in_flight);
    assign fifo_empty = (fifo_cnt == '0);
    assign full       = (occupancy == CW'(FIFO_DEPTH));
    assign frame_done = (state_q == BEAT1) && dmaIbSlave_tReady;

    assign trig_ev  = trigger && !trig_q && enable;
    assign spill_ev = spill && !spill_q;
    assign push     = trig_ev && (!full || frame_done);
    assign drop     = trig_ev && !push;
    assign busy_d   = (32'(occupancy) >= BUSY_THRESH) || (in_flight && full);

    always_ff @(posedge dmaClk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {trig_cnt_q, spill_num_q, ts_q};
        end
    end

    always_ff @(posedge dmaClk or negedge dmaRstL) begin
        if (!dmaRstL) begin
            state_q     <= IDLE;
            trig_q      <= 1'b0;
            spill_q     <= 1'b0;
            ts_q        <= '0;
            spill_num_q <= '0;
            trig_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rec_q       <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trigger;
            spill_q <= spill;
            ts_q    <= ts_q + 48'd1;
            busy_q  <= busy_d;
            if (spill_ev) begin
                spill_num_q <= spill_num_q + 16'd1;
            end
            if (push) begin
                trig_cnt_q <= trig_cnt_q + 32'd1;
                wr_ptr_q   <= wr_ptr_q + CW'(1);
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (pop) begin
                rec_q    <= mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q <= rd_ptr_q + CW'(1);
            end
        end
    end

    // Record layout: {trigNum[95:64], spillNum[63:48], timestamp[47:0]}.
    always_comb begin
        state_d            = state_q;
        pop                = 1'b0;
        dmaIbMaster_tValid = 1'b0;
        dmaIbMaster_tLast  = 1'b0;
        dmaIbMaster_tData  = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                dmaIbMaster_tValid = 1'b1;
                dmaIbMaster_tData  = {8'hA5, 8'h01, rec_q[63:48], rec_q[95:64]};
                if (dmaIbSlave_tReady) begin
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                dmaIbMaster_tValid = 1'b1;
                dmaIbMaster_tLast  = 1'b1;
                dmaIbMaster_tData  = {16'h0000, rec_q[47:0]};
                if (dmaIbSlave_tReady) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = BEAT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmaIbMaster_tKeep = dmaIbMaster_tValid ? 8'hFF : 8'h00;
    assign dmaIbMaster_tDest = FRAME_DEST;
    assign busy              = busy_q;
    assign trigCount         = trig_cnt_q;
    assign dropCount         = drop_cnt_q;

endmodule

// File: tb/tb_trig_frame_builder.sv
// Self-checking bench for trig_frame_builder: scenario tasks compare observed
// stream beats and counters against a record-queue model of the trigger rules.
module tb_trig_frame_builder;

    localparam int DEPTH = 16;
    localparam int THRESH = 12;

    logic        dmaClk = 1'b0;
    logic        dmaRstL = 1'b0;
    logic        enable = 1'b1;
    logic        trigger = 1'b0;
    logic        spill = 1'b0;
    logic        dmaIbSlave_tReady = 1'b0;
    logic        dmaIbMaster_tValid;
    logic [63:0] dmaIbMaster_tData;
    logic [7:0]  dmaIbMaster_tKeep;
    logic        dmaIbMaster_tLast;
    logic [7:0]  dmaIbMaster_tDest;
    logic        busy;
    logic [31:0] trigCount;
    logic [15:0] dropCount;

    trig_frame_builder #(
        .FIFO_DEPTH (DEPTH),
        .BUSY_THRESH(THRESH),
        .FRAME_DEST (8'h00)
    ) dut (
        .dmaClk            (dmaClk),
        .dmaRstL           (dmaRstL),
        .enable            (enable),
        .trigger           (trigger),
        .spill             (spill),
        .dmaIbMaster_tValid(dmaIbMaster_tValid),
        .dmaIbMaster_tData (dmaIbMaster_tData),
        .dmaIbMaster_tKeep (dmaIbMaster_tKeep),
        .dmaIbMaster_tLast (dmaIbMaster_tLast),
        .dmaIbMaster_tDest (dmaIbMaster_tDest),
        .dmaIbSlave_tReady (dmaIbSlave_tReady),
        .busy              (busy),
        .trigCount         (trigCount),
        .dropCount         (dropCount)
    );

    always #5 dmaClk = ~dmaClk;

    typedef struct packed {
        logic [31:0] trig;
        logic [15:0] spill;
        logic [47:0] ts;
    } rec_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [7:0]  keep;
        logic [7:0]  dest;
        logic [47:0] cyc;
    } beat_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [47:0] cyc_q;
    rec_t        exp_q[$];
    beat_t       beat_q[$];
    logic [31:0] m_trig = 0;
    logic [15:0] m_spill = 0;
    logic [15:0] m_drop = 0;
    int          m_pushed = 0;
    int          m_done = 0;

    // Reference time base: cycles elapsed since reset release.
    always @(posedge dmaClk or negedge dmaRstL) begin
        if (!dmaRstL) cyc_q <= '0;
        else          cyc_q <= cyc_q + 48'd1;
    end

    always @(negedge dmaClk) begin
        if (dmaRstL && dmaIbMaster_tValid && dmaIbSlave_tReady) begin
            beat_q.push_back('{dmaIbMaster_tData, dmaIbMaster_tLast,
                               dmaIbMaster_tKeep, dmaIbMaster_tDest, cyc_q});
            if (dmaIbMaster_tLast) m_done++;
        end
    end

    function automatic logic [63:0] beat0_of(input rec_t r);
        return {8'hA5, 8'h01, r.spill, r.trig};
    endfunction

    function automatic logic [63:0] beat1_of(input rec_t r);
        return {16'h0000, r.ts};
    endfunction

    task automatic do_reset();
        dmaRstL = 1'b0;
        trigger = 1'b0;
        spill = 1'b0;
        dmaIbSlave_tReady = 1'b0;
        repeat (3) @(posedge dmaClk);
        beat_q.delete();
        exp_q.delete();
        m_trig = 0;
        m_spill = 0;
        m_drop = 0;
        m_pushed = m_done;
        @(negedge dmaClk);
        #2 dmaRstL = 1'b1;
        @(posedge dmaClk);
        #1;
    endtask

    // One-cycle pulse on trigger and/or spill; the model decides accept/drop.
    task automatic pulse(input bit t, input bit s);
        if (t && enable) begin
            if (m_pushed - m_done < DEPTH) begin
                exp_q.push_back('{m_trig, m_spill, cyc_q});
                m_trig++;
                m_pushed++;
            end else if (m_drop != 16'hFFFF) begin
                m_drop++;
            end
        end
        if (s) m_spill++;
        trigger = t;
        spill = s;
        @(posedge dmaClk);
        #1;
        trigger = 1'b0;
        spill = 1'b0;
        @(posedge dmaClk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (beat_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge dmaClk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge dmaClk);
        n_checks++;
        if (dmaIbMaster_tValid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", dmaIbMaster_tValid); end
        n_checks++;
        if (dmaIbMaster_tLast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got=%b exp=0", dmaIbMaster_tLast); end
        n_checks++;
        if (dmaIbMaster_tData !== 64'h0) begin n_fail++; $display("FAIL reset_tdata got=%h exp=0", dmaIbMaster_tData); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (trigCount !== 32'd0) begin n_fail++; $display("FAIL reset_trigcount got=%0d exp=0", trigCount); end
        n_checks++;
        if (dropCount !== 16'd0) begin n_fail++; $display("FAIL reset_dropcount got=%0d exp=0", dropCount); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit    ok;
        beat_t b0, b1;
        rec_t  r;
        dmaIbSlave_tReady = 1'b1;
        pulse(1'b1, 1'b0);
        wait_beats(2, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout beats=%0d exp=2", beat_q.size());
        end else begin
            b0 = beat_q.pop_front();
            b1 = beat_q.pop_front();
            r = exp_q.pop_front();
            n_checks++;
            if (b0.data !== 64'hA501_0000_0000_0000 || b0.last !== 1'b0)
                begin n_fail++; $display("FAIL single_beat0 got=%h/%b exp=a501000000000000/0", b0.data, b0.last); end
            n_checks++;
            if (b1.data !== {16'h0, r.ts} || b1.last !== 1'b1)
                begin n_fail++; $display("FAIL single_beat1 got=%h/%b exp=%h/1", b1.data, b1.last, {16'h0, r.ts}); end
            n_checks++;
            if (b0.keep !== 8'hFF || b1.keep !== 8'hFF || b0.dest !== 8'h00)
                begin n_fail++; $display("FAIL single_keep_dest got=%h,%h,%h exp=ff,ff,00", b0.keep, b1.keep, b0.dest); end
        end
        n_checks++;
        if (trigCount !== 32'd1) begin n_fail++; $display("FAIL single_trigcount got=%0d exp=1", trigCount); end
        $display("test_single done");
    endtask

    task automatic test_same_cycle_spill();
        bit    ok;
        beat_t b[4];
        rec_t  r;
        do_reset();
        dmaIbSlave_tReady = 1'b1;
        repeat (3) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        wait_beats(4, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL spill_timeout beats=%0d exp=4", beat_q.size());
        end else begin
            for (int i = 0; i < 4; i++) b[i] = beat_q.pop_front();
            n_checks++;
            if (b[0].data[47:32] !== 16'd3) begin n_fail++; $display("FAIL spill_same_cycle got=%0d exp=3", b[0].data[47:32]); end
            n_checks++;
            if (b[2].data[47:32] !== 16'd4) begin n_fail++; $display("FAIL spill_next got=%0d exp=4", b[2].data[47:32]); end
            for (int f = 0; f < 2; f++) begin
                r = exp_q.pop_front();
                n_checks++;
                if (b[2*f].data !== beat0_of(r) || b[2*f+1].data !== beat1_of(r))
                    begin n_fail++; $display("FAIL spill_frame%0d got=%h,%h exp=%h,%h", f, b[2*f].data, b[2*f+1].data, beat0_of(r), beat1_of(r)); end
            end
        end
        $display("test_same_cycle_spill done");
    endtask

    task automatic test_enable();
        do_reset();
        dmaIbSlave_tReady = 1'b1;
        enable = 1'b0;
        repeat (5) pulse(1'b1, 1'b0);
        repeat (10) @(posedge dmaClk);
        #1;
        n_checks++;
        if (beat_q.size() !== 0) begin n_fail++; $display("FAIL enable_frames got=%0d exp=0", beat_q.size()); end
        n_checks++;
        if (trigCount !== 32'd0) begin n_fail++; $display("FAIL enable_trigcount got=%0d exp=0", trigCount); end
        n_checks++;
        if (dropCount !== 16'd0) begin n_fail++; $display("FAIL enable_dropcount got=%0d exp=0", dropCount); end
        enable = 1'b1;
        $display("test_enable done");
    endtask

    task automatic test_fill();
        bit    ok;
        beat_t bl[$];
        rec_t  r;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            pulse(1'b1, 1'b0);
            @(negedge dmaClk);
            n_checks++;
            if (busy !== ((m_pushed - m_done) >= THRESH))
                begin n_fail++; $display("FAIL fill_busy trig=%0d got=%b exp=%b", k, busy, (m_pushed - m_done) >= THRESH); end
            @(posedge dmaClk);
            #1;
        end
        n_checks++;
        if (dropCount !== m_drop) begin n_fail++; $display("FAIL fill_dropcount got=%0d exp=%0d", dropCount, m_drop); end
        n_checks++;
        if (trigCount !== m_trig) begin n_fail++; $display("FAIL fill_trigcount got=%0d exp=%0d", trigCount, m_trig); end
        dmaIbSlave_tReady = 1'b1;
        wait_beats(32, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fill_drain_timeout beats=%0d exp=32", beat_q.size());
        end else begin
            bl = beat_q;
            beat_q.delete();
            for (int f = 0; f < 16; f++) begin
                r = exp_q.pop_front();
                n_checks++;
                if (bl[2*f].data !== beat0_of(r) || bl[2*f].last !== 1'b0 ||
                    bl[2*f+1].data !== beat1_of(r) || bl[2*f+1].last !== 1'b1)
                    begin n_fail++; $display("FAIL fill_frame%0d got=%h,%h exp=%h,%h", f, bl[2*f].data, bl[2*f+1].data, beat0_of(r), beat1_of(r)); end
            end
            n_checks++;
            if (bl[31].cyc - bl[0].cyc !== 48'd31)
                begin n_fail++; $display("FAIL fill_throughput got=%0d cycles exp=31", bl[31].cyc - bl[0].cyc); end
        end
        repeat (3) @(posedge dmaClk);
        @(negedge dmaClk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy_clear got=%b exp=0", busy); end
        $display("test_fill done");
    endtask

    task automatic test_random_stalls();
        int          frames, produced, beat_idx;
        bit          prev_stall, t_lvl, s_lvl;
        logic [63:0] prev_data, exp_d;
        logic        prev_last, exp_l;
        rec_t        r;
        do_reset();
        frames = 0; produced = 0; beat_idx = 0;
        prev_stall = 1'b0; t_lvl = 1'b0; s_lvl = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 20000 && frames < 100; cyc++) begin
            dmaIbSlave_tReady = ($urandom_range(0, 99) < 60);
            if (t_lvl) begin
                if ($urandom_range(0, 1) == 1) t_lvl = 1'b0;
            end else if (produced < 100 && (produced - frames) < 8 && $urandom_range(0, 99) < 35) begin
                t_lvl = 1'b1;
                exp_q.push_back('{m_trig, m_spill, cyc_q});
                m_trig++;
                produced++;
            end
            if ($urandom_range(0, 99) < 20) begin
                if (!s_lvl) m_spill++;
                s_lvl = !s_lvl;
            end
            trigger = t_lvl;
            spill = s_lvl;
            @(negedge dmaClk);
            if (prev_stall) begin
                n_checks++;
                if (dmaIbMaster_tValid !== 1'b1 || dmaIbMaster_tData !== prev_data || dmaIbMaster_tLast !== prev_last)
                    begin n_fail++; $display("FAIL rand_stall_stable got=%b/%h/%b exp=1/%h/%b", dmaIbMaster_tValid, dmaIbMaster_tData, dmaIbMaster_tLast, prev_data, prev_last); end
            end
            if (dmaIbMaster_tValid && dmaIbSlave_tReady) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_beat got=%h exp=no beat", dmaIbMaster_tData);
                end else begin
                    r = exp_q[0];
                    exp_l = beat_idx[0];
                    exp_d = exp_l ? beat1_of(r) : beat0_of(r);
                    if (dmaIbMaster_tData !== exp_d || dmaIbMaster_tLast !== exp_l || dmaIbMaster_tKeep !== 8'hFF)
                        begin n_fail++; $display("FAIL rand_beat%0d got=%h/%b/%h exp=%h/%b/ff", beat_idx, dmaIbMaster_tData, dmaIbMaster_tLast, dmaIbMaster_tKeep, exp_d, exp_l); end
                    if (exp_l) begin
                        void'(exp_q.pop_front());
                        frames++;
                    end
                end
                beat_idx++;
            end
            prev_stall = dmaIbMaster_tValid && !dmaIbSlave_tReady;
            prev_data = dmaIbMaster_tData;
            prev_last = dmaIbMaster_tLast;
            @(posedge dmaClk);
            #1;
        end
        trigger = 1'b0;
        spill = 1'b0;
        dmaIbSlave_tReady = 1'b0;
        n_checks++;
        if (frames != 100) begin n_fail++; $display("FAIL rand_timeout frames=%0d exp=100", frames); end
        n_checks++;
        if (trigCount !== m_trig) begin n_fail++; $display("FAIL rand_trigcount got=%0d exp=%0d", trigCount, m_trig); end
        beat_q.delete();
        $display("test_random_stalls done");
    endtask

    task automatic test_reset_midframe();
        bit    ok;
        beat_t b0, b1;
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (dmaIbMaster_tValid) ok = 1'b1;
            else begin @(posedge dmaClk); #1; end
        end
        dmaIbSlave_tReady = 1'b1;
        @(posedge dmaClk);
        #1;
        dmaIbSlave_tReady = 1'b0;
        @(negedge dmaClk);
        n_checks++;
        if (!ok || dmaIbMaster_tValid !== 1'b1 || dmaIbMaster_tLast !== 1'b1)
            begin n_fail++; $display("FAIL midframe_in_beat1 got=%b/%b exp=1/1", dmaIbMaster_tValid, dmaIbMaster_tLast); end
        #2 dmaRstL = 1'b0;
        trigger = 1'b1;
        #1;
        n_checks++;
        if (dmaIbMaster_tValid !== 1'b0 || dmaIbMaster_tLast !== 1'b0 || dmaIbMaster_tData !== 64'h0)
            begin n_fail++; $display("FAIL midframe_async_out got=%b/%b/%h exp=0/0/0", dmaIbMaster_tValid, dmaIbMaster_tLast, dmaIbMaster_tData); end
        n_checks++;
        if (trigCount !== 32'd0 || dropCount !== 16'd0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL midframe_async_cnt got=%0d/%0d/%b exp=0/0/0", trigCount, dropCount, busy); end
        repeat (2) @(posedge dmaClk);
        beat_q.delete();
        exp_q.delete();
        m_trig = 0;
        m_spill = 0;
        m_drop = 0;
        m_pushed = m_done;
        @(negedge dmaClk);
        #2 dmaRstL = 1'b1;
        @(posedge dmaClk);
        #1;
        trigger = 1'b0;
        dmaIbSlave_tReady = 1'b1;
        wait_beats(2, 40, ok);
        repeat (5) @(posedge dmaClk);
        #1;
        n_checks++;
        if (!ok || beat_q.size() != 2) begin
            n_fail++;
            $display("FAIL midframe_release_beats got=%0d exp=2", beat_q.size());
        end else begin
            b0 = beat_q.pop_front();
            b1 = beat_q.pop_front();
            n_checks++;
            if (b0.data !== 64'hA501_0000_0000_0000 || b0.last !== 1'b0)
                begin n_fail++; $display("FAIL midframe_first_beat0 got=%h/%b exp=a501000000000000/0", b0.data, b0.last); end
            n_checks++;
            if (b1.data !== 64'h0 || b1.last !== 1'b1)
                begin n_fail++; $display("FAIL midframe_first_beat1 got=%h/%b exp=0/1", b1.data, b1.last); end
        end
        n_checks++;
        if (trigCount !== 32'd1) begin n_fail++; $display("FAIL midframe_trigcount got=%0d exp=1", trigCount); end
        dmaIbSlave_tReady = 1'b0;
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle_spill();
        test_enable();
        test_fill();
        test_random_stalls();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
